// File: rtl/fpu_div_pkg.sv
// Shared definitions for the FPU divider exponent/mantissa core.
// Holds default field widths, the exponent bias, the number of extra
// quotient bits, the FSM state encoding and the iteration count helper.
package fpu_div_pkg;

  localparam int EXP_W_DEF    = 8;
  localparam int MAN_W_DEF    = 23;
  localparam int BIAS_DEF     = 127;
  localparam int EXT_BITS_DEF = 2;

  // One quotient bit per ITER cycle: hidden bit + fraction + guard/round.
  localparam int ITER_N_DEF   = MAN_W_DEF + 1 + EXT_BITS_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ALIGN,
    S_ITER,
    S_DONE
  } state_e;

  function automatic int iter_count(input int man_w, input int ext_bits);
    return man_w + 1 + ext_bits;
  endfunction

endpackage

// File: rtl/fp_div_exp_mant_core_if.sv
// Handshake/operand bus of the divider exponent/mantissa core.
//   master : drives start and the unpacked operand fields
//            (Ex_ext/Mx_ext dividend, Ey_ext/My_ext divisor), observes results.
//   slave  : the core; returns busy, done, Ez_div, Q, grs and the status flags
//            ovf, unf, div_by_zero, zero_res.
interface fp_div_exp_mant_core_if
  import fpu_div_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  logic             start;
  logic [EXP_W-1:0] Ex_ext;
  logic [EXP_W-1:0] Ey_ext;
  logic [MAN_W-1:0] Mx_ext;
  logic [MAN_W-1:0] My_ext;

  logic             busy;
  logic             done;
  logic [EXP_W+1:0] Ez_div;
  logic [MAN_W:0]   Q;
  logic [2:0]       grs;
  logic             ovf;
  logic             unf;
  logic             div_by_zero;
  logic             zero_res;

  modport master (
    output start, Ex_ext, Ey_ext, Mx_ext, My_ext,
    input  busy, done, Ez_div, Q, grs, ovf, unf, div_by_zero, zero_res
  );

  modport slave (
    input  start, Ex_ext, Ey_ext, Mx_ext, My_ext,
    output busy, done, Ez_div, Q, grs, ovf, unf, div_by_zero, zero_res
  );
endinterface

// File: rtl/fp_div_step.sv
// Single restoring-division step (combinational).
//   rem, div  : partial remainder and divisor, both W bits
//   rem_next  : (rem-div)<<1 when rem >= div, else rem<<1
//   qbit      : quotient bit produced by this step
module fp_div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_next,
  output logic         qbit
);
  always_comb begin
    qbit     = (rem >= div);
    rem_next = qbit ? ((rem - div) << 1) : (rem << 1);
  end
endmodule

// File: rtl/fp_div_exp_mant_core.sv
// Exponent/mantissa core of the FPU divider.
// Computes the biased quotient exponent Ez = Ex - Ey + BIAS and the
// normalised quotient significand with guard/round/sticky using an
// iterative restoring divider (one quotient bit per cycle).
// Ports:
//   CLK   : clock, rising edge
//   RST   : asynchronous, active-low reset
//   bus   : slave side of fp_div_exp_mant_core_if (start/operands in,
//           busy/done/Ez_div/Q/grs/ovf/unf/div_by_zero/zero_res out)
// Configuration macro FPDIV_DENORM_EN: when defined, denormal operands are
// normalised in a NORM state; when undefined they are flushed to zero.
module fp_div_exp_mant_core
  import fpu_div_pkg::*;
#(
  parameter int EXP_W    = EXP_W_DEF,
  parameter int MAN_W    = MAN_W_DEF,
  parameter int BIAS     = BIAS_DEF,
  parameter int EXT_BITS = EXT_BITS_DEF
) (
  input logic                    CLK,
  input logic                    RST,
  fp_div_exp_mant_core_if.slave  bus
);
  localparam int SIG_W = MAN_W + 1;
  localparam int REM_W = MAN_W + 2;
  localparam int EZ_W  = EXP_W + 2;
  localparam int QB_W  = iter_count(MAN_W, EXT_BITS);
  localparam int CNT_W = $clog2(QB_W + 1);
  // Quotient bits below the round position fold into sticky.
  localparam logic [QB_W-1:0] STK_MASK = QB_W'((64'd1 << (EXT_BITS - 2)) - 64'd1);
  localparam logic [EZ_W-1:0] EZ_MAX   = EZ_W'((1 << EXP_W) - 1);

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [SIG_W-1:0]  sy_q, sy_d;
  logic [EZ_W-1:0]   ez_q, ez_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [QB_W-1:0]   qb_q, qb_d;

  logic [SIG_W-1:0]  q_out_q, q_out_d;
  logic [2:0]        grs_q, grs_d;
  logic [EZ_W-1:0]   ez_out_q, ez_out_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              dbz_q, dbz_d;
  logic              zr_q, zr_d;

  logic              zero_x, zero_y, hx, hy;
  logic [EZ_W-1:0]   ex_eff, ey_eff, ez_new;
  logic [REM_W-1:0]  rem_new, rem_step;
  logic [SIG_W-1:0]  sy_new;
  logic              qbit;

  fp_div_step #(.W(REM_W)) u_step (
    .rem      (rem_q),
    .div      ({1'b0, sy_q}),
    .rem_next (rem_step),
    .qbit     (qbit)
  );

  // Operand classification at launch.
  always_comb begin
`ifdef FPDIV_DENORM_EN
    zero_x = (bus.Ex_ext == '0) && (bus.Mx_ext == '0);
    zero_y = (bus.Ey_ext == '0) && (bus.My_ext == '0);
    hx     = (bus.Ex_ext != '0);
    hy     = (bus.Ey_ext != '0);
    ex_eff = (bus.Ex_ext == '0) ? EZ_W'(1) : EZ_W'(bus.Ex_ext);
    ey_eff = (bus.Ey_ext == '0) ? EZ_W'(1) : EZ_W'(bus.Ey_ext);
`else
    // A zero exponent field means zero: denormals are flushed.
    zero_x = (bus.Ex_ext == '0);
    zero_y = (bus.Ey_ext == '0);
    hx     = 1'b1;
    hy     = 1'b1;
    ex_eff = EZ_W'(bus.Ex_ext);
    ey_eff = EZ_W'(bus.Ey_ext);
`endif
    ez_new  = ex_eff + (EZ_W'(0) - ey_eff) + EZ_W'(BIAS);
    rem_new = {1'b0, hx, bus.Mx_ext};
    sy_new  = {hy, bus.My_ext};
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sy_d     = sy_q;
    ez_d     = ez_q;
    cnt_d    = cnt_q;
    qb_d     = qb_q;
    q_out_d  = q_out_q;
    grs_d    = grs_q;
    ez_out_d = ez_out_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dbz_d    = dbz_q;
    zr_d     = zr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d    = rem_new;
          sy_d     = sy_new;
          ez_d     = ez_new;
          cnt_d    = '0;
          qb_d     = '0;
          q_out_d  = '0;
          grs_d    = '0;
          ez_out_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          dbz_d    = 1'b0;
          zr_d     = 1'b0;
          if (zero_y) begin
            dbz_d    = 1'b1;
            ez_out_d = ez_new;
            state_d  = S_DONE;
          end else if (zero_x) begin
            zr_d     = 1'b1;
            ez_out_d = ez_new;
            state_d  = S_DONE;
          end else begin
`ifdef FPDIV_DENORM_EN
            if (!rem_new[MAN_W] || !sy_new[MAN_W]) state_d = S_NORM;
            else                                    state_d = S_ALIGN;
`else
            state_d = S_ALIGN;
`endif
          end
        end
      end

      S_NORM: begin
`ifdef FPDIV_DENORM_EN
        // Both significands shift together; each shift moves Ez by one.
        if (!rem_q[MAN_W]) begin
          rem_d = rem_q << 1;
        end
        if (!sy_q[MAN_W]) begin
          sy_d = sy_q << 1;
        end
        ez_d = ez_q - EZ_W'(!rem_q[MAN_W]) + EZ_W'(!sy_q[MAN_W]);
        if (rem_d[MAN_W] && sy_d[MAN_W]) state_d = S_ALIGN;
`else
        state_d = S_ALIGN;
`endif
      end

      S_ALIGN: begin
        if (rem_q < {1'b0, sy_q}) begin
          rem_d = rem_q << 1;
          ez_d  = ez_q - EZ_W'(1);
        end
        state_d = S_ITER;
      end

      S_ITER: begin
        rem_d = rem_step;
        qb_d  = {qb_q[QB_W-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(QB_W - 1)) begin
          q_out_d  = qb_d[QB_W-1 -: SIG_W];
          grs_d    = {qb_d[EXT_BITS-1], qb_d[EXT_BITS-2],
                      (|rem_step) | (|(qb_d & STK_MASK))};
          ez_out_d = ez_q;
          ovf_d    = ($signed(ez_q) >= $signed(EZ_MAX));
          unf_d    = ($signed(ez_q) <= $signed(EZ_W'(0)));
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      sy_q     <= '0;
      ez_q     <= '0;
      cnt_q    <= '0;
      qb_q     <= '0;
      q_out_q  <= '0;
      grs_q    <= '0;
      ez_out_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      zr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sy_q     <= sy_d;
      ez_q     <= ez_d;
      cnt_q    <= cnt_d;
      qb_q     <= qb_d;
      q_out_q  <= q_out_d;
      grs_q    <= grs_d;
      ez_out_q <= ez_out_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
      zr_q     <= zr_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.Ez_div      = ez_out_q;
  assign bus.Q           = q_out_q;
  assign bus.grs         = grs_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.zero_res    = zr_q;

endmodule

// File: tb/tb_fp_div_exp_mant_core.sv
// Self-checking bench for fp_div_exp_mant_core: table of directed divide
// vectors plus hand-written sequences for restart-ignore and reset abort.
// Latency is counted in rising edges after the edge that samples start.
module tb_fp_div_exp_mant_core;
  import fpu_div_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  fp_div_exp_mant_core_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_div_exp_mant_core #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(127), .EXT_BITS(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  ex;
    logic [22:0] mx;
    logic [7:0]  ey;
    logic [22:0] my;
    logic [23:0] q;
    logic [9:0]  ez;
    logic        chk_ez;
    logic [2:0]  grs;
    logic        ovf;
    logic        unf;
    logic        dbz;
    logic        zr;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] ex, input logic [22:0] mx,
                     input logic [7:0] ey, input logic [22:0] my,
                     input logic [23:0] q, input logic [9:0] ez, input logic chk_ez,
                     input logic [2:0] grs, input logic ovf, input logic unf,
                     input logic dbz, input logic zr, input int lat);
    vec_t v;
    v.ex = ex; v.mx = mx; v.ey = ey; v.my = my;
    v.q = q; v.ez = ez; v.chk_ez = chk_ez; v.grs = grs;
    v.ovf = ovf; v.unf = unf; v.dbz = dbz; v.zr = zr; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive operands at a falling edge, hold start across one rising edge.
  task automatic launch(input logic [7:0] ex, input logic [22:0] mx,
                        input logic [7:0] ey, input logic [22:0] my);
    @(negedge CLK);
    bus.Ex_ext = ex; bus.Mx_ext = mx; bus.Ey_ext = ey; bus.My_ext = my;
    bus.start  = 1'b1;
    @(posedge CLK);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (!bus.done && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  logic [42:0] all_out;
  assign all_out = {bus.busy, bus.done, bus.Ez_div, bus.Q, bus.grs,
                    bus.ovf, bus.unf, bus.div_by_zero, bus.zero_res};

  initial begin
    int n;
    int seen;
    bus.start = 1'b0;
    bus.Ex_ext = '0; bus.Mx_ext = '0; bus.Ey_ext = '0; bus.My_ext = '0;

    //   ex     mx         ey     my         q          ez       cez grs  ov un dz zr lat
    add(8'd129, 23'h400000, 8'd127, 23'h400000, 24'h800000, 10'd129, 1, 3'b000, 0, 0, 0, 0, 27);
    add(8'd127, 23'h000000, 8'd127, 23'h400000, 24'hAAAAAA, 10'd126, 1, 3'b101, 0, 0, 0, 0, 27);
    add(8'd128, 23'h400000, 8'd127, 23'h000000, 24'hC00000, 10'd128, 1, 3'b000, 0, 0, 0, 0, 27);
    add(8'd127, 23'h000000, 8'd128, 23'h400000, 24'hAAAAAA, 10'd125, 1, 3'b101, 0, 0, 0, 0, 27);
    add(8'd127, 23'h600000, 8'd127, 23'h200000, 24'hB33333, 10'd127, 1, 3'b001, 0, 0, 0, 0, 27);
    add(8'd254, 23'h000000, 8'd1,   23'h000000, 24'h800000, 10'd380, 1, 3'b000, 1, 0, 0, 0, 27);
    add(8'd1,   23'h000000, 8'd254, 23'h000000, 24'h800000, 10'h382, 1, 3'b000, 0, 1, 0, 0, 27);
    add(8'd130, 23'h000005, 8'd0,   23'h000000, 24'h000000, 10'd0,   0, 3'b000, 0, 0, 1, 0, 0);
    add(8'd0,   23'h000000, 8'd127, 23'h000000, 24'h000000, 10'd0,   0, 3'b000, 0, 0, 0, 1, 0);
    add(8'd0,   23'h000000, 8'd0,   23'h000000, 24'h000000, 10'd0,   0, 3'b000, 0, 0, 1, 0, 0);
`ifdef FPDIV_DENORM_EN
    add(8'd0,   23'h200000, 8'd127, 23'h000000, 24'h800000, 10'h3FF, 1, 3'b000, 0, 1, 0, 0, 29);
    add(8'd127, 23'h000000, 8'd0,   23'h400000, 24'h800000, 10'd254, 1, 3'b000, 0, 0, 0, 0, 28);
`else
    add(8'd0,   23'h200000, 8'd127, 23'h000000, 24'h000000, 10'd0,   0, 3'b000, 0, 0, 0, 1, 0);
    add(8'd127, 23'h000000, 8'd0,   23'h400000, 24'h000000, 10'd0,   0, 3'b000, 0, 0, 1, 0, 0);
`endif

    #2;
    chk("reset_outputs", 64'(all_out), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].ex, vecs[i].mx, vecs[i].ey, vecs[i].my);
      n = 0;
      wait_done(n);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat));
      chk($sformatf("v%0d_q", i), 64'(bus.Q), 64'(vecs[i].q));
      chk($sformatf("v%0d_grs", i), 64'(bus.grs), 64'(vecs[i].grs));
      chk($sformatf("v%0d_flags", i),
          64'({bus.ovf, bus.unf, bus.div_by_zero, bus.zero_res}),
          64'({vecs[i].ovf, vecs[i].unf, vecs[i].dbz, vecs[i].zr}));
      if (vecs[i].chk_ez) chk($sformatf("v%0d_ez", i), 64'(bus.Ez_div), 64'(vecs[i].ez));
      chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd1);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 64'({bus.done, bus.busy}), 64'd0);
      chk($sformatf("v%0d_q_held", i), 64'(bus.Q), 64'(vecs[i].q));
    end

    // Start re-pulsed mid-ITER with different operands must be ignored.
    launch(8'd129, 23'h400000, 8'd127, 23'h400000);
    n = 0;
    repeat (12) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    bus.Ex_ext = 8'd127; bus.Mx_ext = 23'h0; bus.Ey_ext = 8'd127; bus.My_ext = 23'h400000;
    bus.start  = 1'b1;
    @(posedge CLK);
    n++;
    #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("restart_latency", 64'(n), 64'd27);
    chk("restart_q", 64'(bus.Q), 64'h800000);
    chk("restart_ez", 64'(bus.Ez_div), 64'd129);
    chk("restart_grs", 64'(bus.grs), 64'd0);

    // Reset asserted at ITER cycle 10 aborts with no done pulse.
    @(posedge CLK);
    launch(8'd127, 23'h000000, 8'd127, 23'h400000);
    repeat (11) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("abort_outputs", 64'(all_out), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Recovery after abort.
    launch(8'd128, 23'h400000, 8'd127, 23'h000000);
    n = 0;
    wait_done(n);
    chk("recover_latency", 64'(n), 64'd27);
    chk("recover_q", 64'(bus.Q), 64'hC00000);
    chk("recover_ez", 64'(bus.Ez_div), 64'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
